// File: rtl/phase_accumulator.sv
// Numerically controlled oscillator: integrates a tuning word into a phase register and
// maps phase to a signed WI.WF sine sample through a pipelined quarter-wave ROM.
module phase_accumulator #(
    parameter int NUM_BITS = 32,
    parameter int LUT_BITS = 10,
    parameter int WI       = 2,
    parameter int WF       = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       phase_reset,
    input  logic [NUM_BITS-1:0]        tuning_word,
    output logic [NUM_BITS-1:0]        phase_out,
    output logic signed [WI+WF-1:0]    sine_out,
    output logic                       valid_out
);

    localparam int DEPTH = 1 << LUT_BITS;
    localparam int SW    = WI + WF;

    // Taylor series keeps ROM generation to plain real arithmetic at elaboration.
    function automatic real quarterSine(input real x);
        real term;
        real sum;
        term = x;
        sum  = x;
        for (int n = 1; n < 16; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic logic [WF-1:0] romEntry(input int k);
        real    angle;
        real    scaled;
        longint rounded;
        angle   = (real'(k) + 0.5) * 3.14159265358979323846 / real'(2 ** (LUT_BITS + 1));
        scaled  = quarterSine(angle) * real'((2 ** WF) - 1);
        rounded = longint'(scaled);
        return rounded[WF-1:0];
    endfunction

    logic [WF-1:0] romTable [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam logic [WF-1:0] ENTRY = romEntry(k);
        assign romTable[k] = ENTRY;
    end

    logic [NUM_BITS-1:0] phase_q,    phase_d;
    logic                accValid_q, accValid_d;
    logic [LUT_BITS-1:0] s1Addr_q,   s1Addr_d;
    logic                s1Neg_q,    s1Neg_d;
    logic                s1Valid_q,  s1Valid_d;
    logic [WF-1:0]       s2Data_q,   s2Data_d;
    logic                s2Neg_q,    s2Neg_d;
    logic                s2Valid_q,  s2Valid_d;
    logic [SW-1:0]       sine_q,     sine_d;
    logic                valid_q,    valid_d;

    logic [1:0]          quadrant;
    logic [LUT_BITS-1:0] index;
    logic [SW-1:0]       magnitude;

    always_comb begin
        phase_d = phase_q;
        if (phase_reset) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = phase_q + tuning_word;
        end
        accValid_d = en;

        // Odd quadrants walk the quarter wave backwards.
        quadrant  = phase_q[NUM_BITS-1 -: 2];
        index     = phase_q[NUM_BITS-3 -: LUT_BITS];
        s1Addr_d  = quadrant[0] ? ~index : index;
        s1Neg_d   = quadrant[1];
        s1Valid_d = accValid_q;

        s2Data_d  = romTable[s1Addr_q];
        s2Neg_d   = s1Neg_q;
        s2Valid_d = s1Valid_q;

        magnitude = {{WI{1'b0}}, s2Data_q};
        sine_d    = sine_q;
        if (s2Valid_q) begin
            sine_d = s2Neg_q ? (~magnitude + 1'b1) : magnitude;
        end
        valid_d = s2Valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q    <= '0;
            accValid_q <= 1'b0;
            s1Addr_q   <= '0;
            s1Neg_q    <= 1'b0;
            s1Valid_q  <= 1'b0;
            s2Data_q   <= '0;
            s2Neg_q    <= 1'b0;
            s2Valid_q  <= 1'b0;
            sine_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            accValid_q <= accValid_d;
            s1Addr_q   <= s1Addr_d;
            s1Neg_q    <= s1Neg_d;
            s1Valid_q  <= s1Valid_d;
            s2Data_q   <= s2Data_d;
            s2Neg_q    <= s2Neg_d;
            s2Valid_q  <= s2Valid_d;
            sine_q     <= sine_d;
            valid_q    <= valid_d;
        end
    end

    assign phase_out = phase_q;
    assign sine_out  = sine_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_phase_accumulator.sv
// Scoreboard bench for phase_accumulator: stimulus pushes expected samples computed from
// the ideal sine of the quantised phase; a monitor pops them whenever valid_out fires.
module tb_phase_accumulator;

    localparam int    NUM_BITS = 32;
    localparam int    LUT_BITS = 10;
    localparam int    WI       = 2;
    localparam int    WF       = 16;
    localparam int    SW       = WI + WF;
    localparam int    STEPS    = 1 << (LUT_BITS + 2);
    localparam real   PI       = 3.14159265358979323846;

    typedef struct {
        logic [SW-1:0] sine;
        int            due;
    } expect_t;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0;
    logic                phase_reset = 1'b0;
    logic [NUM_BITS-1:0] tuning_word = '0;
    logic [NUM_BITS-1:0] phase_out;
    logic [SW-1:0]       sine_out;
    logic                valid_out;

    int                  testsRun = 0;
    int                  testsFailed = 0;
    int                  cycle = 0;
    logic [NUM_BITS-1:0] modelPhase = '0;
    expect_t             expQ[$];
    logic [SW-1:0]       seenLog[$];

    phase_accumulator #(
        .NUM_BITS(NUM_BITS), .LUT_BITS(LUT_BITS), .WI(WI), .WF(WF)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .phase_reset(phase_reset),
        .tuning_word(tuning_word), .phase_out(phase_out),
        .sine_out(sine_out), .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Ideal sine sampled at the centre of the phase bin selected by the top address bits.
    function automatic logic [SW-1:0] sineModel(input logic [NUM_BITS-1:0] ph);
        int  bin;
        real angle;
        int  value;
        bin   = int'(ph >> (NUM_BITS - LUT_BITS - 2));
        angle = 2.0 * PI * (real'(bin) + 0.5) / real'(STEPS);
        value = int'($sin(angle) * real'((2 ** WF) - 1));
        return SW'(value);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic enV, input logic prV,
                                 input logic [NUM_BITS-1:0] tw, input logic rstV);
        en          = enV;
        phase_reset = prV;
        tuning_word = tw;
        rst         = rstV;
        @(posedge clk);
        #1;
        if (rstV) begin
            modelPhase = '0;
            expQ.delete();
        end else begin
            if (prV) modelPhase = '0;
            else if (enV) modelPhase = modelPhase + tw;
            if (enV) expQ.push_back('{sine: sineModel(modelPhase), due: cycle + 3});
        end
        checkOutput("phase_out", phase_out, modelPhase);
    endtask

    task automatic drain();
        repeat (8) applyStimulus(1'b0, 1'b0, $urandom, 1'b0);
        checkOutput("pending samples", expQ.size(), 0);
    endtask

    // Monitor: every valid_out must match the oldest outstanding expectation on its due cycle.
    always @(negedge clk) begin
        expect_t e;
        if (valid_out) begin
            seenLog.push_back(sine_out);
            if (expQ.size() == 0) begin
                checkOutput("unexpected valid_out", 1, 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("sine_out", sine_out, e.sine);
                checkOutput("valid_out latency", cycle, e.due);
            end
        end
        while (expQ.size() > 0 && expQ[0].due < cycle) begin
            e = expQ.pop_front();
            $display("[TB] FAIL missing valid_out: got none by cycle %0d, expected at %0d", cycle, e.due);
            testsRun++;
            testsFailed++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            base;
        int            errs;
        logic [SW-1:0] holdSine;
        logic [SW-1:0] walkGold [4];
        walkGold[0] = 18'h0FFFF;
        walkGold[1] = 18'h3FFCE;
        walkGold[2] = 18'h30001;
        walkGold[3] = 18'h00032;

        repeat (2) applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("reset sine_out", sine_out, 0);
        checkOutput("reset valid_out", valid_out, 0);

        // Quadrant walk.
        base = seenLog.size();
        repeat (4) applyStimulus(1'b1, 1'b0, 32'h4000_0000, 1'b0);
        drain();
        checkOutput("walk sample count", seenLog.size() - base, 4);
        for (int k = 0; k < 4; k++) begin
            if (seenLog.size() > base + k) checkOutput("walk golden", seenLog[base + k], walkGold[k]);
        end

        // Mid-pipeline reset, with a strobe in the reset cycle.
        base = seenLog.size();
        applyStimulus(1'b1, 1'b0, 32'h1111_1111, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h2222_2222, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h3333_3333, 1'b1);
        drain();
        checkOutput("no valid after reset", seenLog.size() - base, 0);

        // Sync priority over increment.
        applyStimulus(1'b1, 1'b0, 32'h1234_5678, 1'b0);
        base = seenLog.size();
        applyStimulus(1'b1, 1'b1, 32'h0000_0100, 1'b0);
        drain();
        checkOutput("sync sample count", seenLog.size() - base, 2);
        if (seenLog.size() > 0) checkOutput("sync golden", seenLog[seenLog.size() - 1], 18'h00032);

        // Wrap-around, then gating.
        applyStimulus(1'b0, 1'b1, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FF00, 1'b0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0200, 1'b0);
        checkOutput("wrap phase", phase_out, 32'h0000_0100);
        drain();
        holdSine = sine_out;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, $urandom, 1'b0);
            checkOutput("gated sine hold", sine_out, holdSine);
            checkOutput("gated valid low", valid_out, 0);
        end

        // Sparse strobes.
        base = seenLog.size();
        for (int k = 0; k < 256; k++) begin
            applyStimulus(1'b1, 1'b0, 32'h0100_0000, 1'b0);
            repeat (3) applyStimulus(1'b0, 1'b0, $urandom, 1'b0);
        end
        drain();
        checkOutput("sparse sample count", seenLog.size() - base, 256);

        // Full sweep with odd symmetry.
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        base = seenLog.size();
        for (int k = 0; k < STEPS; k++) begin
            applyStimulus(1'b1, 1'b0, 32'(1) << (NUM_BITS - LUT_BITS - 2), 1'b0);
        end
        drain();
        checkOutput("sweep sample count", seenLog.size() - base, STEPS);
        errs = 0;
        if (seenLog.size() >= base + STEPS) begin
            for (int n = 0; n < STEPS / 2; n++) begin
                if (seenLog[base + n + STEPS / 2] !== SW'(-seenLog[base + n])) errs++;
            end
        end
        checkOutput("sweep odd symmetry errors", errs, 0);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            applyStimulus(1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0),
                          $urandom, ($urandom_range(0, 63) == 0));
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
